// File: rtl/event_mon_pkg.sv
// Shared defaults and record type for the event monitor blocks.
package event_mon_pkg;
  localparam int EVT_N     = 4;
  localparam int EVT_W     = 72;
  localparam int EVT_DEPTH = 4;

  typedef logic [EVT_W-1:0] event_rec_t;
endpackage

// File: rtl/event_push_arbiter_rr_arbiter.sv
// Round-robin selector: searches from ptr+1 (mod N) and grants the first active request.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  int unsigned j;
  logic        found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    if (en) begin
      for (int unsigned i = 1; i <= N; i++) begin
        j = (int'(ptr) + i) % N;
        if (!found && req[j]) begin
          found    = 1'b1;
          grant[j] = 1'b1;
          idx      = IW'(j);
        end
      end
    end
  end
endmodule

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and sticky overflow flag.
module sync_fifo #(
  parameter int W     = 72,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full     = (count == DEPTH[$clog2(DEPTH+1)-1:0]);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full) overflow <= 1'b1;
    end
  end
endmodule

// File: rtl/event_push_arbiter.sv
// Round-robin arbiter pushing one event record per cycle into a downstream FIFO,
// with lossy/backpressure modes and per-requester saturating drop counters.
module event_push_arbiter
  import event_mon_pkg::*;
#(
  parameter int N     = EVT_N,
  parameter int W     = EVT_W,
  parameter int DEPTH = EVT_DEPTH,
  parameter int CW    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               req_valid,
  input  logic [N*W-1:0]             req_data,
  output logic [N-1:0]               req_ready,
  input  logic                       lossy_en,
  input  logic                       clr_drop,
  input  logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       fifo_push,
  output logic [W-1:0]               fifo_push_data,
  output logic [$clog2(N)-1:0]       grant_id,
  output logic [N*CW-1:0]            drop_cnt
);
  localparam int IW  = $clog2(N);
  localparam int FCW = $clog2(DEPTH+1);

  logic [IW-1:0] rr_ptr, win_idx;
  logic [N-1:0]  win, drop;
  logic [FCW:0]  used;
  logic          has_room, grant_any;
  logic [CW-1:0] cnt [N];

  // The registered push lands in the FIFO on the coming edge, so it already occupies a slot.
  assign used      = {1'b0, fifo_count} + {{FCW{1'b0}}, fifo_push};
  assign has_room  = (used < (FCW+1)'(DEPTH));
  assign grant_any = |win;

  rr_arbiter #(.N(N), .IW(IW)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .en    (has_room && !rst),
    .grant (win),
    .idx   (win_idx)
  );

  always_comb begin
    req_ready = '0;
    drop      = '0;
    if (!rst) begin
      if (has_room) begin
        req_ready = win;
      end else if (lossy_en) begin
        req_ready = req_valid;
        drop      = req_valid;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_push      <= 1'b0;
      fifo_push_data <= '0;
      grant_id       <= '0;
      rr_ptr         <= IW'(N-1);
    end else begin
      fifo_push <= grant_any;
      if (grant_any) begin
        fifo_push_data <= req_data[int'(win_idx)*W +: W];
        grant_id       <= win_idx;
        rr_ptr         <= win_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (clr_drop)                   cnt[i] <= drop[i] ? CW'(1) : '0;
        else if (drop[i] && cnt[i] != '1) cnt[i] <= cnt[i] + CW'(1);
      end
    end
  end

  always_comb begin
    drop_cnt = '0;
    for (int unsigned i = 0; i < N; i++) drop_cnt[i*CW +: CW] = cnt[i];
  end
endmodule

// File: tb/tb_event_push_arbiter.sv
// Scoreboard bench: event_push_arbiter feeding a 4-deep sync_fifo.
module tb_event_push_arbiter;
  import event_mon_pkg::*;

  localparam int N     = 4;
  localparam int W     = 72;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int FCW   = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic             lossy_en, clr_drop;
  logic [FCW-1:0]   fifo_count;
  logic             fifo_push;
  logic [W-1:0]     fifo_push_data;
  logic [1:0]       grant_id;
  logic [N*CW-1:0]  drop_cnt;
  logic             pop;
  logic [W-1:0]     pop_data;
  logic             full, empty, overflow;

  int total = 0;
  int bad   = 0;
  int push_q[$];
  int pop_q[$];

  always #5 clk = ~clk;

  event_push_arbiter #(.N(N), .W(W), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .lossy_en(lossy_en), .clr_drop(clr_drop),
    .fifo_count(fifo_count), .fifo_push(fifo_push),
    .fifo_push_data(fifo_push_data), .grant_id(grant_id), .drop_cnt(drop_cnt)
  );

  sync_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(fifo_push), .push_data(fifo_push_data),
    .pop(pop), .pop_data(pop_data), .count(fifo_count), .full(full),
    .empty(empty), .overflow(overflow)
  );

  function automatic logic [W-1:0] pl(input int i);
    return {8'(8'h10 + i), 32'(32'hDEAD0000 + i), 32'(32'h0BEE0000 ^ (i * 32'h1111))};
  endfunction

  function automatic logic [CW-1:0] cnt_of(input int i);
    return drop_cnt[i*CW +: CW];
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every push and every pop is matched against the queued expectations.
  always @(negedge clk) begin
    int id;
    if (rst === 1'b0) begin
      if (fifo_push === 1'b1) begin
        if (push_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_push: got grant_id %0d with no push expected", grant_id);
        end else begin
          id = push_q.pop_front();
          check("push_id", W'(grant_id), W'(id));
          check("push_data", fifo_push_data, pl(id));
        end
      end
      if (pop === 1'b1) begin
        if (pop_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pop: got %0h with no pop expected", pop_data);
        end else begin
          id = pop_q.pop_front();
          check("pop_data", pop_data, pl(id));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req_valid = '1; lossy_en = 1'b0; clr_drop = 1'b0; pop = 1'b0;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = pl(i);

    // Reset state, with all requesters valid.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_push", W'(fifo_push), '0);
    check("rst_data", fifo_push_data, '0);
    check("rst_id", W'(grant_id), '0);
    check("rst_ready", W'(req_ready), '0);
    check("rst_drop", W'(drop_cnt), '0);

    // Fill: four consecutive pushes 0,1,2,3, then backpressure.
    for (int i = 0; i < 4; i++) push_q.push_back(i);
    @(posedge clk); #1 rst = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    check("full_ready", W'(req_ready), '0);
    check("full_count", W'(fifo_count), W'(4));
    check("full_ovf", W'(overflow), '0);

    // One pop per 3 cycles: rotation continues, popped records in source order.
    begin
      int exp_ids[6] = '{0, 1, 2, 3, 0, 1};
      for (int k = 0; k < 6; k++) begin
        push_q.push_back(exp_ids[k]);
        pop_q.push_back(exp_ids[k]);
      end
    end
    tick();
    for (int k = 0; k < 6; k++) begin
      pop = 1'b1;
      tick();
      pop = 1'b0;
      tick();
      tick();
    end
    req_valid = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rot_count", W'(fifo_count), W'(4));
    check("rot_queues", W'(push_q.size() + pop_q.size()), '0);

    // Lossy drops with full FIFO, requesters 0 and 2 for 5 cycles.
    tick();
    req_valid = 4'b0101; lossy_en = 1'b1;
    @(negedge clk);
    check("lossy_ready", W'(req_ready), W'(4'b0101));
    repeat (5) @(posedge clk);
    #1 req_valid = '0; lossy_en = 1'b0;
    @(negedge clk);
    check("drop0_5", W'(cnt_of(0)), W'(5));
    check("drop1_0", W'(cnt_of(1)), '0);
    check("drop2_5", W'(cnt_of(2)), W'(5));
    check("drop3_0", W'(cnt_of(3)), '0);
    check("nolossy_ready", W'(req_ready), '0);

    // Saturation at 2^CW-1 and clear-with-drop.
    tick();
    req_valid = 4'b0001; lossy_en = 1'b1;
    repeat (9) @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check("drop0_max_m1", W'(cnt_of(0)), W'((1 << CW) - 2));
    tick();
    req_valid = 4'b0001;
    repeat (3) @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check("drop0_sat", W'(cnt_of(0)), W'((1 << CW) - 1));
    tick();
    req_valid = 4'b0001; clr_drop = 1'b1;
    @(posedge clk);
    #1 req_valid = '0; clr_drop = 1'b0; lossy_en = 1'b0;
    @(negedge clk);
    check("clr_drop0", W'(cnt_of(0)), W'(1));
    check("clr_drop2", W'(cnt_of(2)), '0);

    // Single requester 2 with room for exactly one record.
    tick();
    pop_q.push_back(2);
    pop = 1'b1;
    tick();
    pop = 1'b0; req_valid = 4'b0100;
    push_q.push_back(2);
    @(negedge clk);
    check("r2_ready", W'(req_ready), W'(4'b0100));
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      check("r2_ready_off", W'(req_ready), '0);
    end
    tick();
    pop_q.push_back(3);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    push_q.push_back(2);
    @(negedge clk);
    check("r2_ready_again", W'(req_ready), W'(4'b0100));
    tick();
    req_valid = '0;
    repeat (2) tick();
    @(negedge clk);
    check("pre_rst_ovf", W'(overflow), '0);

    // Reset the cycle after an accept; requester 0 first after release.
    tick();
    pop_q.push_back(0);
    pop = 1'b1;
    tick();
    pop = 1'b0; req_valid = 4'b1111;
    @(negedge clk);
    check("acc_ready", W'(req_ready), W'(4'b1000));
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst2_push", W'(fifo_push), '0);
    check("rst2_drop", W'(drop_cnt), '0);
    check("rst2_ready", W'(req_ready), '0);
    push_q.push_back(0);
    tick();
    rst = 1'b0;
    tick();
    req_valid = '0;
    repeat (4) tick();
    @(negedge clk);
    check("post_count", W'(fifo_count), W'(1));
    check("post_ovf", W'(overflow), '0);
    check("end_push_q", W'(push_q.size()), '0);
    check("end_pop_q", W'(pop_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/event_push_arbiter.md
EVENT_PUSH_ARBITER -- requirements
Module: event_push_arbiter

Interface
REQ-001 Parameter N, default 4: number of event requesters.
REQ-002 Parameter W, default 72: event record width in bits.
REQ-003 Parameter DEPTH, default 4: depth of the downstream sync FIFO.
REQ-004 Parameter CW, default 16: width of each per-requester drop counter.
REQ-005 clk  in  1  the only clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 req_valid  in  N  per-requester event valid.
REQ-008 req_data  in  N*W  per-requester event record; requester i occupies bits [i*W +: W].
REQ-009 req_ready  out  N  per-requester accept; a transfer occurs when valid and ready are both 1 at a clock edge.
REQ-010 lossy_en  in  1  1 = drop events when there is no room; 0 = apply backpressure.
REQ-011 clr_drop  in  1  synchronous clear of all drop counters.
REQ-012 fifo_count  in  $clog2(DEPTH+1)  current occupancy reported by the FIFO.
REQ-013 fifo_push  out  1  registered push strobe to the FIFO.
REQ-014 fifo_push_data  out  W  registered push data to the FIFO.
REQ-015 grant_id  out  $clog2(N)  registered index of the requester whose event is on fifo_push_data.
REQ-016 drop_cnt  out  N*CW  per-requester saturating drop counters; requester i occupies bits [i*CW +: CW].

Function
REQ-017 room SHALL equal DEPTH - fifo_count - fifo_push, computed without underflow; a grant SHALL be issued only when room > 0.
REQ-018 When room > 0 and at least one req_valid is 1, exactly one requester SHALL be granted, chosen round-robin: the search starts at rr_ptr+1 (mod N), and the first valid requester found wins.
REQ-019 req_ready SHALL be 1 only for the granted requester in a grant cycle, and SHALL be combinational from req_valid, rr_ptr, room and lossy_en.
REQ-020 On a grant, the following edge SHALL set fifo_push=1, fifo_push_data to the winner's req_data and grant_id to the winner's index, and SHALL set rr_ptr to the winner's index; latency from accept to push is 1 cycle.
REQ-021 In a cycle with no grant, fifo_push SHALL be 0 at the next edge, and fifo_push_data and grant_id SHALL hold their values.
REQ-022 When room == 0 and lossy_en == 0, all req_ready SHALL be 0 and all counters SHALL hold.
REQ-023 When room == 0 and lossy_en == 1, req_ready SHALL equal req_valid, and every valid requester's drop_cnt SHALL increment by 1; rr_ptr SHALL hold.
REQ-024 Drop counters SHALL saturate at 2^CW-1 and SHALL NOT wrap.
REQ-025 When clr_drop == 1, each counter SHALL load 1 if its requester drops in that same cycle and 0 otherwise.
REQ-026 Back-to-back grants SHALL be possible every cycle while room > 0; no cycle is lost between pushes.
REQ-027 The block SHALL never push while the FIFO is full, so the FIFO overflow flag stays 0 under any stimulus.
REQ-028 lossy_en changes SHALL take effect in the same cycle.

Reset
REQ-029 While rst=1: fifo_push=0, fifo_push_data=0, grant_id=0, rr_ptr=N-1 (requester 0 has first priority), all drop_cnt=0, and req_ready=0 regardless of inputs.
REQ-030 An accept in flight when reset asserts SHALL be discarded; no push occurs on the first edge after reset release.

Structure
REQ-031 W, N, DEPTH defaults and the event record typedef SHALL live in the shared package event_mon_pkg.
REQ-032 The round-robin selection SHALL be a sub-module rr_arbiter (inputs: req, ptr, en; outputs: one-hot grant and index).
REQ-033 The bench SHALL instantiate this block driving sync_fifo with DEPTH=4, and SHALL wire fifo_count from the FIFO.

Verification
REQ-034 Reset, then req_valid=4'b1111 held with the FIFO never popped -> 4 pushes in the source order 0,1,2,3 on consecutive cycles, then req_ready=0 and the FIFO overflow flag stays 0.
REQ-035 Continue with one pop per 3 cycles while all four requesters are valid -> grants continue the rotation 0,1,2,3,...; each popped record carries the expected source payload.
REQ-036 Full FIFO, lossy_en=1, req_valid=4'b0101 for 5 cycles -> drop_cnt[0]=5, drop_cnt[2]=5, drop_cnt[1]=drop_cnt[3]=0, no push.
REQ-037 Force drop_cnt[0]=2^CW-2 via drops, then 3 more drops -> drop_cnt[0] holds at 2^CW-1; then clr_drop together with a drop -> drop_cnt[0]=1.
REQ-038 Only requester 2 valid, room=1 -> req_ready=4'b0100 for exactly one cycle, fifo_push next cycle with grant_id=2, then ready stays 0 until a pop.
REQ-039 Assert rst the cycle after an accept -> fifo_push=0 immediately, drop_cnt=0, and after release requester 0 is granted first.
